// File: rtl/net_pkg.sv
// Shared types and constants for the network stack transmit path.
// Holds the TX arbiter state encoding and RMII timing constants.
package net_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        STREAM,
        GAP
    } tx_arb_state_t;

    // 96 bit-times at 2 bits/clk, plus 4 clocks to drain the final byte
    localparam int IFG_CYCLES_RMII = 52;
    localparam int MAX_REQ         = 8;

endpackage

// File: rtl/rr_pick.sv
// Purpose: combinational round-robin picker, first set req bit after rr_ptr with wrap.
// Latency: zero cycles, pure combinational.
// Backpressure: none; the caller decides when to consume idx/any.
module rr_pick
    import net_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]                                 req,
    input  logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0]   rr_ptr,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0]   idx,
    output logic                                               any
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
        $error("rr_pick: NUM_REQ out of range");
    end

    logic [IW-1:0] cand;

    // Walk from farthest to nearest so the nearest candidate after rr_ptr wins.
    always_comb begin
        idx  = '0;
        cand = '0;
        any  = |req;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (rr_ptr >= IW'(NUM_REQ - k)) begin
                cand = rr_ptr - IW'(NUM_REQ - k);
            end else begin
                cand = rr_ptr + IW'(k);
            end
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Purpose: round-robin share of the RMII TX serializer, one whole frame per grant, then inter-frame gap.
// Latency: one GRANT cycle before data; bytes pass combinationally in STREAM; IFG_CYCLES idle after last byte.
// Backpressure: axior mirrored to the granted source's axiir; stalled or withdrawn sources are aborted.
module eth_tx_arbiter
    import net_pkg::*;
#(
    parameter int NUM_REQ       = 2,
    parameter int IFG_CYCLES    = IFG_CYCLES_RMII,
    parameter int STALL_TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   axiid,
    input  logic [NUM_REQ-1:0]     axiiv,
    input  logic [NUM_REQ-1:0]     axiil,
    output logic [NUM_REQ-1:0]     axiir,
    output logic [NUM_REQ-1:0]     grant,
    output logic [7:0]             axiod,
    output logic                   axiov,
    output logic                   axiol,
    input  logic                   axior,
    output logic                   tx_abort,
    output logic                   busy
);

    localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_MAX = (IFG_CYCLES > STALL_TIMEOUT) ? IFG_CYCLES : STALL_TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] GAP_LOAD   = CW'(IFG_CYCLES - 1);
    localparam logic [CW-1:0] STALL_LAST = CW'(STALL_TIMEOUT - 1);

    tx_arb_state_t state, state_nxt;
    logic [IW-1:0] sel, sel_nxt;
    logic [IW-1:0] rr_ptr, rr_ptr_nxt;
    logic [CW-1:0] gap_cnt, gap_cnt_nxt;
    logic [CW-1:0] stall_cnt, stall_cnt_nxt;
    logic [IW-1:0] pick_idx;
    logic          pick_any;
    logic [7:0]    sel_dat;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign sel_dat = axiid[{sel, 3'b000} +: 8];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sel       <= '0;
            rr_ptr    <= IW'(NUM_REQ - 1);
            gap_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            state     <= state_nxt;
            sel       <= sel_nxt;
            rr_ptr    <= rr_ptr_nxt;
            gap_cnt   <= gap_cnt_nxt;
            stall_cnt <= stall_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        sel_nxt       = sel;
        rr_ptr_nxt    = rr_ptr;
        gap_cnt_nxt   = gap_cnt;
        stall_cnt_nxt = stall_cnt;
        grant         = '0;
        axiir         = '0;
        axiod         = '0;
        axiov         = 1'b0;
        axiol         = 1'b0;
        tx_abort      = 1'b0;
        busy          = (state != IDLE);

        case (state)
            IDLE: begin
                if (pick_any) begin
                    sel_nxt    = pick_idx;
                    rr_ptr_nxt = pick_idx;
                    state_nxt  = GRANT;
                end
            end
            GRANT: begin
                grant[sel]    = 1'b1;
                stall_cnt_nxt = '0;
                state_nxt     = STREAM;
            end
            STREAM: begin
                grant[sel] = 1'b1;
                if (!req[sel]) begin
                    // Withdrawn mid-frame: suppress this cycle's byte and drop the frame.
                    tx_abort    = 1'b1;
                    gap_cnt_nxt = GAP_LOAD;
                    state_nxt   = GAP;
                end else begin
                    axiov      = axiiv[sel];
                    axiol      = axiil[sel];
                    axiod      = sel_dat;
                    axiir[sel] = axior;
                    if (axiiv[sel] && axior) begin
                        stall_cnt_nxt = '0;
                        if (axiil[sel]) begin
                            gap_cnt_nxt = GAP_LOAD;
                            state_nxt   = GAP;
                        end
                    end else if (!axiiv[sel]) begin
                        if (stall_cnt == STALL_LAST) begin
                            tx_abort    = 1'b1;
                            gap_cnt_nxt = GAP_LOAD;
                            state_nxt   = GAP;
                        end else begin
                            stall_cnt_nxt = stall_cnt + 1'b1;
                        end
                    end
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    gap_cnt_nxt = gap_cnt - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Directed bench for eth_tx_arbiter: behavioural byte sources and a serializer with a ready pattern.
module tb_eth_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req;
    logic [15:0] axiid;
    logic [1:0]  axiiv;
    logic [1:0]  axiil;
    logic [1:0]  axiir;
    logic [1:0]  grant;
    logic [7:0]  axiod;
    logic        axiov;
    logic        axiol;
    logic        axior;
    logic        tx_abort;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    // Source model
    bit         s_req [2];
    bit         s_vld [2];
    bit         s_rep [2];
    int         s_len [2];
    int         s_ptr [2];
    logic [7:0] s_base[2];
    int         s_done[2];
    int         ser_period = 1;
    int         cyc = 0;
    bit         rst_drv = 1'b1;

    logic [7:0] fwd_dat [$];
    logic       fwd_last[$];
    logic [1:0] fwd_src [$];

    eth_tx_arbiter #(.NUM_REQ(2), .IFG_CYCLES(52), .STALL_TIMEOUT(64)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .axiid    (axiid),
        .axiiv    (axiiv),
        .axiil    (axiil),
        .axiir    (axiir),
        .grant    (grant),
        .axiod    (axiod),
        .axiov    (axiov),
        .axiol    (axiol),
        .axior    (axior),
        .tx_abort (tx_abort),
        .busy     (busy)
    );

    always #10 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    // One clock: drive inputs at negedge, let them settle, then log what crosses the edge.
    task automatic step();
        @(negedge clk);
        cyc++;
        rst   = rst_drv;
        axior = ((cyc % ser_period) == 0);
        for (int i = 0; i < 2; i++) begin
            req[i]           = s_req[i];
            axiiv[i]         = s_vld[i];
            axiid[8*i +: 8]  = s_base[i] + 8'(s_ptr[i]);
            axiil[i]         = (s_ptr[i] == s_len[i] - 1);
        end
        #1;
        if (axiov && axior) begin
            fwd_dat.push_back(axiod);
            fwd_last.push_back(axiol);
            fwd_src.push_back(grant);
        end
        for (int i = 0; i < 2; i++) begin
            if (axiiv[i] && axiir[i]) begin
                if (axiil[i]) begin
                    s_done[i]++;
                    s_ptr[i] = 0;
                    if (!s_rep[i]) s_req[i] = 1'b0;
                end else begin
                    s_ptr[i]++;
                end
            end else if (tx_abort && grant[i]) begin
                s_ptr[i] = 0;
            end
        end
    endtask

    task automatic do_reset();
        rst_drv    = 1'b1;
        ser_period = 1;
        for (int i = 0; i < 2; i++) begin
            s_req[i] = 1'b0; s_vld[i] = 1'b1; s_rep[i] = 1'b0;
            s_len[i] = 1;    s_ptr[i] = 0;    s_done[i] = 0; s_base[i] = 8'h00;
        end
        repeat (3) step();
        rst_drv = 1'b0;
        fwd_dat.delete(); fwd_last.delete(); fwd_src.delete();
    endtask

    task automatic test_reset();
        do_reset();
        s_req[0] = 1'b1; s_req[1] = 1'b1; s_len[0] = 4; s_len[1] = 4;
        rst_drv = 1'b1;
        repeat (3) step();
        n_cmp++; if (grant !== 2'b00) begin n_bad++; $display("FAIL reset_grant: got %b want 00", grant); end
        n_cmp++; if (axiir !== 2'b00) begin n_bad++; $display("FAIL reset_axiir: got %b want 00", axiir); end
        n_cmp++; if (axiov !== 1'b0) begin n_bad++; $display("FAIL reset_axiov: got %b want 0", axiov); end
        n_cmp++; if (axiol !== 1'b0) begin n_bad++; $display("FAIL reset_axiol: got %b want 0", axiol); end
        n_cmp++; if (axiod !== 8'h00) begin n_bad++; $display("FAIL reset_axiod: got %h want 00", axiod); end
        n_cmp++; if (tx_abort !== 1'b0) begin n_bad++; $display("FAIL reset_abort: got %b want 0", tx_abort); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst_drv = 1'b0;
        step();
        n_cmp++; if (grant !== 2'b00) begin n_bad++; $display("FAIL reset_idle_cycle: got grant %b want 00", grant); end
        step();
        n_cmp++; if (grant !== 2'b01) begin n_bad++; $display("FAIL reset_first_grant: got %b want 01", grant); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL reset_busy_grant: got %b want 1", busy); end
    endtask

    task automatic test_single_frame();
        int g, d, h, b, bad;
        do_reset();
        s_len[0] = 64; s_base[0] = 8'h00; s_req[0] = 1'b1;
        g = -1; d = -1; h = -1; b = -1; bad = 0;
        for (int t = 0; t < 400; t++) begin
            step();
            if (g < 0 && grant != 2'b00) begin
                g = cyc;
                n_cmp++; if (grant !== 2'b01) begin n_bad++; $display("FAIL single_grant: got %b want 01", grant); end
                n_cmp++; if (axiir !== 2'b00) begin n_bad++; $display("FAIL single_grant_axiir: got %b want 00", axiir); end
            end
            if (d < 0 && axiov) d = cyc;
            if (axiov && axior && axiol) h = cyc;
            if (h >= 0 && cyc > h && !busy) begin b = cyc; break; end
        end
        n_cmp++; if (d !== g + 1) begin n_bad++; $display("FAIL single_data_latency: got cycle %0d want %0d", d, g + 1); end
        n_cmp++; if (fwd_dat.size() != 64) begin n_bad++; $display("FAIL single_count: got %0d want 64", fwd_dat.size()); end
        for (int k = 0; k < fwd_dat.size(); k++)
            if (fwd_dat[k] !== 8'(k) || fwd_last[k] !== (k == 63)) bad++;
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL single_bytes: got %0d bad bytes want 0", bad); end
        n_cmp++; if (b < 0 || (b - h - 1) != 52) begin n_bad++; $display("FAIL single_gap: got %0d gap cycles want 52", b - h - 1); end
    endtask

    task automatic test_alternate();
        logic [1:0] order[4];
        logic [1:0] prev;
        int n_gr, last_h, bad, src;
        do_reset();
        s_len[0] = 10; s_len[1] = 10; s_base[0] = 8'h10; s_base[1] = 8'h80;
        s_req[0] = 1'b1; s_req[1] = 1'b1; s_rep[0] = 1'b1; s_rep[1] = 1'b1;
        n_gr = 0; last_h = -1; prev = 2'b00; bad = 0;
        for (int t = 0; t < 600 && (s_done[0] + s_done[1]) < 4; t++) begin
            step();
            if (prev == 2'b00 && grant != 2'b00 && n_gr < 4) begin
                order[n_gr] = grant;
                if (n_gr > 0) begin
                    n_cmp++; if (cyc - last_h != 54) begin n_bad++; $display("FAIL alt_gap%0d: got %0d cycles want 54", n_gr, cyc - last_h); end
                end
                n_gr++;
            end
            if (axiov && axior && axiol) last_h = cyc;
            prev = grant;
        end
        n_cmp++; if (n_gr != 4) begin n_bad++; $display("FAIL alt_grants: got %0d want 4", n_gr); end
        n_cmp++; if (order[0] !== 2'b01 || order[1] !== 2'b10 || order[2] !== 2'b01 || order[3] !== 2'b10)
            begin n_bad++; $display("FAIL alt_order: got %b %b %b %b want 01 10 01 10", order[0], order[1], order[2], order[3]); end
        n_cmp++; if (fwd_dat.size() != 40) begin n_bad++; $display("FAIL alt_count: got %0d want 40", fwd_dat.size()); end
        for (int j = 0; j < fwd_dat.size() && j < 40; j++) begin
            src = (j / 10) % 2;
            if (fwd_dat[j] !== s_base[src] + 8'(j % 10) || fwd_last[j] !== ((j % 10) == 9) || fwd_src[j] !== 2'(1 << src)) bad++;
        end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL alt_bytes: got %0d bad bytes want 0", bad); end
    endtask

    task automatic test_slow_serializer();
        logic [1:0] prev;
        int mirror_bad, aborts, bad;
        do_reset();
        ser_period = 4;
        s_len[0] = 16; s_base[0] = 8'h40; s_req[0] = 1'b1;
        prev = 2'b00; mirror_bad = 0; aborts = 0; bad = 0;
        for (int t = 0; t < 400 && s_done[0] < 1; t++) begin
            step();
            if (prev == 2'b01 && grant == 2'b01 && (axiir[0] !== axior || axiir[1] !== 1'b0)) mirror_bad++;
            if (tx_abort) aborts++;
            prev = grant;
        end
        n_cmp++; if (s_done[0] != 1) begin n_bad++; $display("FAIL slow_done: got %0d frames want 1", s_done[0]); end
        n_cmp++; if (mirror_bad != 0) begin n_bad++; $display("FAIL slow_mirror: got %0d bad cycles want 0", mirror_bad); end
        n_cmp++; if (aborts != 0) begin n_bad++; $display("FAIL slow_abort: got %0d aborts want 0", aborts); end
        n_cmp++; if (fwd_dat.size() != 16) begin n_bad++; $display("FAIL slow_count: got %0d want 16", fwd_dat.size()); end
        for (int k = 0; k < fwd_dat.size(); k++)
            if (fwd_dat[k] !== 8'h40 + 8'(k) || fwd_last[k] !== (k == 15)) bad++;
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL slow_bytes: got %0d bad bytes want 0", bad); end
    endtask

    task automatic test_stall_abort();
        int stall_cyc, abort_at, abort_cyc, aborts, regrant;
        bit stalling;
        do_reset();
        s_len[1] = 20; s_base[1] = 8'hA0; s_req[1] = 1'b1;
        stall_cyc = 0; abort_at = -1; abort_cyc = -1; aborts = 0; regrant = -1; stalling = 0;
        for (int t = 0; t < 400; t++) begin
            step();
            if (stalling && axiiv[1] == 1'b0 && grant[1]) stall_cyc++;
            if (tx_abort) begin
                aborts++;
                if (abort_cyc < 0) begin abort_at = stall_cyc; abort_cyc = cyc; s_vld[1] = 1'b1; end
            end else if (abort_cyc >= 0 && cyc == abort_cyc + 1) begin
                n_cmp++; if (grant !== 2'b00 || busy !== 1'b1) begin n_bad++; $display("FAIL stall_gap_entry: got grant %b busy %b want 00 1", grant, busy); end
            end else if (abort_cyc >= 0 && grant != 2'b00) begin
                regrant = cyc; break;
            end
            if (!stalling && s_ptr[1] == 5) begin s_vld[1] = 1'b0; stalling = 1; end
        end
        n_cmp++; if (abort_at != 64) begin n_bad++; $display("FAIL stall_abort_cycle: got %0d want 64", abort_at); end
        n_cmp++; if (aborts != 1) begin n_bad++; $display("FAIL stall_abort_count: got %0d want 1", aborts); end
        n_cmp++; if (fwd_dat.size() != 5) begin n_bad++; $display("FAIL stall_fwd_count: got %0d want 5", fwd_dat.size()); end
        n_cmp++; if (regrant < 0 || regrant - abort_cyc != 54 || grant !== 2'b10)
            begin n_bad++; $display("FAIL stall_regrant: got %0d cycles grant %b want 54 10", regrant - abort_cyc, grant); end
    endtask

    task automatic test_drop_req();
        int drop, gapn;
        bit ok;
        do_reset();
        s_len[0] = 10; s_base[0] = 8'h30; s_req[0] = 1'b1;
        drop = 0; gapn = 0; ok = 0;
        for (int t = 0; t < 300; t++) begin
            step();
            if (drop == 1) begin
                n_cmp++; if (tx_abort !== 1'b1) begin n_bad++; $display("FAIL drop_abort: got %b want 1", tx_abort); end
                n_cmp++; if (axiov !== 1'b0) begin n_bad++; $display("FAIL drop_axiov: got %b want 0", axiov); end
                drop = 2;
            end else if (drop == 2) begin
                if (busy && grant == 2'b00) gapn++;
                else if (!busy) begin ok = 1; break; end
            end
            if (drop == 0 && s_ptr[0] == 3) begin s_req[0] = 1'b0; drop = 1; end
        end
        n_cmp++; if (!ok || gapn != 52) begin n_bad++; $display("FAIL drop_gap: got %0d gap cycles want 52", gapn); end
        n_cmp++; if (fwd_dat.size() != 3 || fwd_dat[0] !== 8'h30 || fwd_dat[2] !== 8'h32)
            begin n_bad++; $display("FAIL drop_bytes: got %0d bytes want 3 (30..32)", fwd_dat.size()); end
    endtask

    task automatic test_reset_mid_frame();
        bit reached;
        do_reset();
        s_len[0] = 40; s_len[1] = 40; s_base[1] = 8'h80;
        s_req[0] = 1'b1; s_req[1] = 1'b1;
        reached = 0;
        for (int t = 0; t < 200; t++) begin
            step();
            if (s_ptr[0] == 20) begin reached = 1; break; end
        end
        n_cmp++; if (!reached) begin n_bad++; $display("FAIL mid_reach: got ptr %0d want 20", s_ptr[0]); end
        rst_drv = 1'b1;
        step();
        step();
        n_cmp++; if (grant !== 2'b00 || axiir !== 2'b00) begin n_bad++; $display("FAIL mid_grant: got %b/%b want 00/00", grant, axiir); end
        n_cmp++; if (axiov !== 1'b0 || axiol !== 1'b0 || axiod !== 8'h00) begin n_bad++; $display("FAIL mid_data: got %b %b %h want 0 0 00", axiov, axiol, axiod); end
        n_cmp++; if (tx_abort !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL mid_abort_busy: got %b %b want 0 0", tx_abort, busy); end
        s_ptr[0] = 0; s_ptr[1] = 0;
        rst_drv = 1'b0;
        reached = 0;
        for (int t = 0; t < 10; t++) begin
            step();
            if (grant != 2'b00) begin reached = 1; break; end
        end
        n_cmp++; if (!reached || grant !== 2'b01) begin n_bad++; $display("FAIL mid_first_grant: got %b want 01", grant); end
    endtask

    initial begin
        req = '0; axiid = '0; axiiv = '0; axiil = '0; axior = 1'b0;
        test_reset();
        test_single_frame();
        test_alternate();
        test_slow_serializer();
        test_stall_abort();
        test_drop_req();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/eth_tx_arbiter.md
Name: eth_tx_arbiter

Overview:
- Shares the single RMII transmit serializer (byte stream in, eth_txen/eth_txd out) between NUM_REQ frame sources, e.g. ARP responder and transport_tx.
- Round-robin grants one whole frame at a time, muxes that source's byte stream to the serializer, then enforces the inter-frame gap.
- Aborts a frame whose source stalls or drops its request mid-frame.
- Sits between the TX-side protocol builders and ethernet_tx inside network_stack.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- IFG_CYCLES, 52, idle clk cycles after the last byte is accepted before the next grant (48 for 96 bit-times at 2 bits/clk, plus 4 to drain the last byte).
- STALL_TIMEOUT, 64, consecutive cycles with no valid byte from the granted source before abort.

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  synchronous active-high reset.
- req  in  NUM_REQ  per-source frame request; held high through its last byte.
- axiid  in  8*NUM_REQ  per-source data byte; source i uses bits [8i+7:8i].
- axiiv  in  NUM_REQ  per-source byte valid.
- axiil  in  NUM_REQ  per-source last-byte flag, qualified by axiiv.
- axiir  out  NUM_REQ  per-source ready.
- grant  out  NUM_REQ  one-hot grant, or all zero.
- axiod  out  8  byte to serializer.
- axiov  out  1  byte valid to serializer.
- axiol  out  1  last byte to serializer.
- axior  in  1  serializer ready.
- tx_abort  out  1  one-cycle pulse: serializer must drop the current frame.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: state=IDLE; rr_ptr=NUM_REQ-1, so source 0 has first priority. Outputs: grant=0, axiir=0, axiov=0, axiol=0, axiod=0, tx_abort=0, busy=0. Internal gap_cnt=0, stall_cnt=0.
- Reset mid-frame: returns to IDLE on the next edge. No abort pulse and no gap.
- Handshake: a byte transfers when axiov && axior.
  - axiov, axiol and axiod pass through combinationally from the granted source in STREAM only.
  - axiir[sel] = axior in STREAM; all other axiir bits are 0.
- IDLE: when req is nonzero, pick the first set bit scanning from rr_ptr+1 upward with wrap. Latch it as sel, set rr_ptr=sel, go to GRANT.
- GRANT: one cycle. grant[sel]=1 and axiir=0. Go to STREAM.
- STREAM: grant[sel] held.
  - Transfer with axiil[sel]=1: go to GAP and load gap_cnt=IFG_CYCLES-1.
  - Any transfer: clears stall_cnt.
  - Cycle with axiiv[sel]=0: increments stall_cnt. When stall_cnt reaches STALL_TIMEOUT-1, assert tx_abort for 1 cycle and go to GAP.
  - req[sel]=0 before its last byte: tx_abort the same cycle; that cycle's byte is not forwarded (axiov forced 0); go to GAP.
  - Cycle with axiov && !axior: data is held by the source, and stall_cnt does not count.
- GAP: grant=0, axiov=0. gap_cnt decrements each cycle; at 0 go to IDLE. Requests arriving during GAP wait.
- Priority: an abort or last byte and a new request in the same cycle resolve as abort/last first. The new request is served after the gap.
- busy=1 in GRANT, STREAM and GAP.
- Widths: gap_cnt and stall_cnt use $clog2(max(IFG_CYCLES,STALL_TIMEOUT)+1) bits. No wrap is possible.
- A zero-byte frame (req with no data) is covered by the stall timeout.

Decomposition:
- net_pkg holds:
  - the enum for tx_arb_state_t {IDLE, GRANT, STREAM, GAP};
  - localparam IFG_CYCLES_RMII=52;
  - localparam MAX_REQ=8.
- Sub-module rr_pick (NUM_REQ): combinational round-robin picker. Inputs: req, rr_ptr. Outputs: idx, any. Unit-tested separately.

Test Plan:
- Source 0 sends a 64-byte frame, axior always 1, source 1 idle -> grant=01 one cycle before data, 64 bytes forwarded in order, axiol on byte 64, busy low exactly 52 cycles after the last-byte handshake.
- Both req high from reset, 10-byte frames each -> source 0 first, then source 1 after 52 gap cycles, then source 0 again (alternation verified over 4 frames).
- Serializer drives axior=1 every 4th cycle -> axiir[sel] mirrors axior, no byte lost or duplicated, and stall_cnt never reaches abort.
- Source 1 stops asserting axiiv after byte 5 for 64 cycles -> tx_abort pulses once on cycle 64 of the stall, then GAP, then grant returns to IDLE arbitration.
- Source 0 drops req after byte 3 -> tx_abort the same cycle, axiov=0 that cycle, gap enforced.
- rst asserted mid-STREAM at byte 20 -> all outputs 0 next cycle. After release with both req high, source 0 is granted first.
